// File: rtl/demux_1_n_stream_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : demux_1_n_stream_if                                          |
// | Description : Stream bus between one producer and N_CH output consumers.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface demux_1_n_stream_if #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 8,
  parameter int SEL_W  = 3
);

  logic                 mode;
  logic [SEL_W-1:0]     in_sel;
  logic [DATA_W-1:0]    in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    out_data;
  logic [N_CH-1:0]      out_valid;
  logic [N_CH-1:0]      out_ready;

  modport master (
    output mode,
    output in_sel,
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  mode,
    input  in_sel,
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );

endinterface
`default_nettype wire

// File: rtl/demux_1_n_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : demux_1_n_stream                                             |
// | Description : Registered 1-to-N valid/ready stream demux with addressed or |
// |               round-robin routing and sticky out-of-range select flag.     |
// |               Optional macro DEMUX_ZERO_IDLE_EN forces out_data to zero    |
// |               while no beat is held.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module demux_1_n_stream #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 8,
  parameter int SEL_W  = 3
) (
  input  wire logic             clk,
  input  wire logic             rst,
  demux_1_n_stream_if.slave     bus,
  output logic [SEL_W-1:0]      scan_ptr,
  input  wire logic             err_clr,
  output logic                  err_sel
);

  localparam int              C_PTR_SPAN = 2 ** SEL_W;
  localparam logic [SEL_W:0]  C_N_CH     = (SEL_W + 1)'(N_CH);
  localparam logic [SEL_W-1:0] C_LAST_CH = SEL_W'(N_CH - 1);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    hc_q, hc_d;
  logic [SEL_W-1:0]    scan_q, scan_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;

  logic [C_PTR_SPAN-1:0] w_ready_ext;
  logic                  w_held_ready;
  logic                  w_in_ready;
  logic                  w_accept;
  logic [SEL_W-1:0]      w_target;
  logic                  w_in_range;
  logic                  w_load;
  logic                  w_drop;
  logic                  w_deliver;
  logic [N_CH-1:0]       w_valid;

  // Pad ready to the full pointer span so the held index never runs off the end.
  assign w_ready_ext  = C_PTR_SPAN'(bus.out_ready);
  assign w_held_ready = w_ready_ext[hc_q];

  assign w_in_ready = (state_q == ST_EMPTY) || w_held_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_target   = bus.mode ? scan_q : bus.in_sel;
  assign w_in_range = ({1'b0, w_target} < C_N_CH);
  assign w_load     = w_accept && w_in_range;
  assign w_drop     = w_accept && !w_in_range;
  assign w_deliver  = (state_q == ST_FULL) && w_held_ready;

  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    data_d  = data_q;
    scan_d  = scan_q;
    err_d   = err_q;

    // A new beat overrides a simultaneous delivery, giving one beat per cycle.
    if (w_load) begin
      state_d = ST_FULL;
      hc_d    = w_target;
      data_d  = bus.in_data;
    end else if (w_deliver) begin
      state_d = ST_EMPTY;
    end

    if (w_accept && bus.mode) begin
      scan_d = (scan_q == C_LAST_CH) ? '0 : scan_q + 1'b1;
    end

    if (w_drop) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      hc_q    <= '0;
      data_q  <= '0;
      scan_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      data_q  <= data_d;
      scan_q  <= scan_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    w_valid = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_valid[k] = (state_q == ST_FULL) && (hc_q == SEL_W'(k));
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_valid;
  assign scan_ptr      = scan_q;
  assign err_sel       = err_q;

`ifdef DEMUX_ZERO_IDLE_EN
  assign bus.out_data = (state_q == ST_FULL) ? data_q : '0;
`else
  assign bus.out_data = data_q;
`endif

endmodule
`default_nettype wire
